// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, muxA select codes, flag bit positions and multiplier
// state type shared by the BIP accumulator datapath and its multiplier.
package bip_pkg;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_XORI = 5'b01101;
  localparam logic [4:0] OP_SHL  = 5'b01110;
  localparam logic [4:0] OP_SAR  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;

  localparam logic [1:0] SEL_A_DATA = 2'b00;
  localparam logic [1:0] SEL_A_OPER = 2'b01;
  localparam logic [1:0] SEL_A_ALU  = 2'b10;
  localparam logic [1:0] SEL_A_HOLD = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/bip_seq_mul.sv
// bip_seq_mul: unsigned shift-add multiplier, one multiplier bit per cycle.
// The first partial product is folded into the start edge, so the full
// product sits in prod_q during the last RUN cycle, when o_done pulses.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   MUL_IDLE | waiting for i_start; operands sampled on the start edge
//   MUL_RUN  | NB_DATA cycles; cnt_q counts remaining add steps down,
//            | terminal count 0 marks the done cycle
module bip_seq_mul import bip_pkg::*; #(
  parameter int NB_DATA = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [NB_DATA-1:0]     i_a,
  input  logic [NB_DATA-1:0]     i_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [2*NB_DATA-1:0]   o_prod
);

  localparam int NB_CNT = $clog2(NB_DATA);

  mul_state_e            state_q, state_d;
  logic [NB_CNT-1:0]     cnt_q, cnt_d;
  logic [2*NB_DATA-1:0]  prod_q, prod_d;
  logic [2*NB_DATA-1:0]  mcand_q, mcand_d;
  logic [NB_DATA-1:0]    mplier_q, mplier_d;
  logic                  done;

  // state and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // next-state and shift-add step
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    done     = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (i_start) begin
          state_d  = MUL_RUN;
          cnt_d    = NB_CNT'(NB_DATA - 1);
          prod_d   = i_b[0] ? {{NB_DATA{1'b0}}, i_a} : '0;
          mcand_d  = {{(NB_DATA-1){1'b0}}, i_a, 1'b0};
          mplier_d = i_b >> 1;
        end
      end
      MUL_RUN: begin
        if (cnt_q != '0) begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - NB_CNT'(1);
        end else begin
          done    = 1'b1;
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign o_busy = (state_q == MUL_RUN);
  assign o_done = done;
  assign o_prod = prod_q;

endmodule

// File: rtl/bip_alu_datapath.sv
// bip_alu_datapath: BIP accumulator with extended ALU, {N,Z,C,V} flags and
// a valid/ready issue handshake. Define BIP_MUL_EN to add the sequential
// multiplier (opcode 10000); without it that opcode just holds acc/flags.
module bip_alu_datapath import bip_pkg::*; #(
  parameter int NB_DATA     = 16,
  parameter int NB_OPERANDO = 11,
  parameter int NB_OPCODE   = 5,
  parameter int NB_SEL_A    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [NB_SEL_A-1:0]    i_selA,
  input  logic                   i_selB,
  input  logic                   i_wrAcc,
  input  logic [NB_OPCODE-1:0]   i_op,
  input  logic [NB_OPERANDO-1:0] i_operando,
  input  logic [NB_DATA-1:0]     i_data,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic [NB_DATA-1:0]     o_data,
  output logic [3:0]             o_flags
);

  logic [NB_DATA-1:0]  acc_q, acc_d;
  logic [3:0]          flags_q, flags_d;
  logic [NB_DATA-1:0]  ext_oper, opb, alu_res;
  logic [NB_DATA:0]    sum_ext, dif_ext, shl_ext, sar_ext;
  logic                alu_c, alu_v, alu_fupd;
  logic                single_wr;
  logic                wr_en, wr_fupd;
  logic [NB_SEL_A-1:0] wr_sel;
  logic [NB_DATA-1:0]  wr_res;
  logic [3:0]          wr_flags;

  assign ext_oper = {{(NB_DATA-NB_OPERANDO){i_operando[NB_OPERANDO-1]}}, i_operando};
  assign opb      = i_selB ? ext_oper : i_data;
  assign sum_ext  = {1'b0, acc_q} + {1'b0, opb};
  assign dif_ext  = {1'b0, acc_q} - {1'b0, opb};
  // the bit pushed past either end of the extended word is the shifted-out carry
  assign shl_ext  = {1'b0, acc_q} << opb[3:0];
  assign sar_ext  = $signed({acc_q, 1'b0}) >>> opb[3:0];

  // single-cycle ALU result and carry/overflow
  always_comb begin
    alu_res  = acc_q;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_fupd = 1'b1;
    case (i_op)
      OP_HLT: alu_res = '0;
      OP_ADD, OP_ADDI: begin
        alu_res = sum_ext[NB_DATA-1:0];
        alu_c   = sum_ext[NB_DATA];
        alu_v   = (acc_q[NB_DATA-1] == opb[NB_DATA-1]) &&
                  (alu_res[NB_DATA-1] != acc_q[NB_DATA-1]);
      end
      OP_SUB, OP_SUBI: begin
        alu_res = dif_ext[NB_DATA-1:0];
        alu_c   = dif_ext[NB_DATA];
        alu_v   = (acc_q[NB_DATA-1] != opb[NB_DATA-1]) &&
                  (alu_res[NB_DATA-1] != acc_q[NB_DATA-1]);
      end
      OP_AND, OP_ANDI: alu_res = acc_q & opb;
      OP_OR,  OP_ORI:  alu_res = acc_q | opb;
      OP_XOR, OP_XORI: alu_res = acc_q ^ opb;
      OP_SHL: begin
        alu_res = shl_ext[NB_DATA-1:0];
        alu_c   = shl_ext[NB_DATA];
      end
      OP_SAR: begin
        alu_res = sar_ext[NB_DATA:1];
        alu_c   = sar_ext[0];
      end
      OP_MUL:  alu_fupd = 1'b0;
      default: ;
    endcase
  end

`ifdef BIP_MUL_EN
  logic                  mul_start, mul_busy, mul_done;
  logic [2*NB_DATA-1:0]  mul_prod;
  logic [NB_SEL_A-1:0]   mul_sel_q;
  logic                  mul_wr_q;

  assign o_busy    = mul_busy;
  assign o_ready   = ~mul_busy;
  assign mul_start = i_valid & o_ready & (i_op == OP_MUL);
  assign single_wr = i_valid & o_ready & i_wrAcc & ~mul_start;

  bip_seq_mul #(.NB_DATA(NB_DATA)) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mul_start),
    .i_a     (acc_q),
    .i_b     (opb),
    .o_busy  (mul_busy),
    .o_done  (mul_done),
    .o_prod  (mul_prod)
  );

  // write controls captured at MUL issue, applied when the product lands
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mul_sel_q <= '0;
      mul_wr_q  <= 1'b0;
    end else if (mul_start) begin
      mul_sel_q <= i_selA;
      mul_wr_q  <= i_wrAcc;
    end
  end
`else
  assign o_busy    = 1'b0;
  assign o_ready   = 1'b1;
  assign single_wr = i_valid & i_wrAcc;
`endif

  // pick the write source: the MUL completion never overlaps an accept
  always_comb begin
    wr_en    = single_wr;
    wr_sel   = i_selA;
    wr_res   = alu_res;
    wr_fupd  = alu_fupd;
    wr_flags = '0;
    wr_flags[FLAG_N] = alu_res[NB_DATA-1];
    wr_flags[FLAG_Z] = (alu_res == '0);
    wr_flags[FLAG_C] = alu_c;
    wr_flags[FLAG_V] = alu_v;
`ifdef BIP_MUL_EN
    if (mul_done) begin
      wr_en    = mul_wr_q;
      wr_sel   = mul_sel_q;
      wr_res   = mul_prod[NB_DATA-1:0];
      wr_fupd  = 1'b1;
      wr_flags = '0;
      wr_flags[FLAG_N] = mul_prod[NB_DATA-1];
      wr_flags[FLAG_Z] = (mul_prod[NB_DATA-1:0] == '0);
      wr_flags[FLAG_C] = (mul_prod[2*NB_DATA-1:NB_DATA] != '0);
    end
`endif
  end

  // muxA into the accumulator; flags follow only ALU-sourced writes
  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    if (wr_en) begin
      case (wr_sel)
        SEL_A_DATA: acc_d = i_data;
        SEL_A_OPER: acc_d = ext_oper;
        SEL_A_ALU: begin
          acc_d = wr_res;
          if (wr_fupd) flags_d = wr_flags;
        end
        default: ;
      endcase
    end
  end

  // accumulator and flag registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  assign o_data  = acc_q;
  assign o_flags = flags_q;

endmodule

// File: tb/tb_bip_alu_datapath.sv
// Testbench for bip_alu_datapath: directed scenarios plus randomized
// instructions checked against an arithmetic reference model.
module tb_bip_alu_datapath;

`ifdef BIP_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_selA = '0;
  logic        i_selB = 1'b0;
  logic        i_wrAcc = 1'b0;
  logic [4:0]  i_op = '0;
  logic [10:0] i_operando = '0;
  logic [15:0] i_data = '0;
  logic        o_ready, o_busy;
  logic [15:0] o_data;
  logic [3:0]  o_flags;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_acc = '0;
  logic [3:0]  m_flags = '0;

  bip_alu_datapath dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_selA(i_selA),
    .i_selB(i_selB), .i_wrAcc(i_wrAcc), .i_op(i_op), .i_operando(i_operando),
    .i_data(i_data), .o_ready(o_ready), .o_busy(o_busy), .o_data(o_data),
    .o_flags(o_flags)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference ALU from arithmetic definitions; flags packed {N,Z,C,V}.
  function automatic void ref_alu(input logic [4:0] op, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] r,
                                  output logic [3:0] f, output bit fu);
    int ua, ub, sa, sb, s, n;
    bit c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    n = int'(b[3:0]);
    c = 0; v = 0; fu = 1; r = a;
    case (op)
      5'b00000: r = 16'h0000;
      5'b00100, 5'b00101: begin
        s = ua + ub; r = s[15:0]; c = (s > 65535);
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      5'b00110, 5'b00111: begin
        s = ua - ub; r = s[15:0]; c = (ua < ub);
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      5'b01000, 5'b01001: r = a & b;
      5'b01010, 5'b01011: r = a | b;
      5'b01100, 5'b01101: r = a ^ b;
      5'b01110: begin
        s = ua << n; r = s[15:0];
        c = (n == 0) ? 1'b0 : ((ua >> (16 - n)) & 1) != 0;
      end
      5'b01111: begin
        s = sa >>> n; r = s[15:0];
        c = (n == 0) ? 1'b0 : ((ua >> (n - 1)) & 1) != 0;
      end
      5'b10000: fu = 0;
      default: ;
    endcase
    f = {r[15], (r == 16'h0000), c, v};
  endfunction

  // Drive one instruction for one clock and advance the model (non-MUL ops).
  task automatic issue(input bit v, input logic [4:0] op, input logic [1:0] sa,
                       input bit sb, input bit wr, input logic [10:0] oper,
                       input logic [15:0] data);
    logic [15:0] ext, b, r;
    logic [3:0]  f;
    bit fu;
    @(negedge i_clk);
    i_valid = v; i_op = op; i_selA = sa; i_selB = sb; i_wrAcc = wr;
    i_operando = oper; i_data = data;
    ext = {{5{oper[10]}}, oper};
    b = sb ? ext : data;
    ref_alu(op, m_acc, b, r, f, fu);
    if (v && wr && !(MUL_ON && op == 5'b10000)) begin
      case (sa)
        2'd0: m_acc = data;
        2'd1: m_acc = ext;
        2'd2: begin m_acc = r; if (fu) m_flags = f; end
        default: ;
      endcase
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    #3;
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_acc: got %h want 0000", o_data); end
    checks++; if (o_flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", o_flags); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    @(negedge i_clk); i_rst = 1'b1;
    m_acc = '0; m_flags = '0;
    @(posedge i_clk); #1;
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_release_acc: got %h want 0000", o_data); end
  endtask

  task automatic test_arith();
    issue(1, 5'b00101, 2'd2, 1, 1, 11'd5, 16'h0);
    issue(1, 5'b00111, 2'd2, 1, 1, 11'd7, 16'h0);
    checks++; if (o_data !== 16'hFFFE) begin errors++; $display("FAIL addsub_acc: got %h want fffe", o_data); end
    checks++; if (o_flags !== 4'b1010) begin errors++; $display("FAIL addsub_flags: got %b want 1010", o_flags); end
    issue(1, 5'b00000, 2'd0, 0, 1, 11'd0, 16'h7FFF);
    issue(1, 5'b00101, 2'd2, 1, 1, 11'd1, 16'h0);
    checks++; if (o_data !== 16'h8000) begin errors++; $display("FAIL ovf_acc: got %h want 8000", o_data); end
    checks++; if (o_flags !== 4'b1001) begin errors++; $display("FAIL ovf_flags: got %b want 1001", o_flags); end
    issue(1, 5'b00100, 2'd2, 0, 1, 11'd0, 16'h8000);
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL carry_acc: got %h want 0000", o_data); end
    checks++; if (o_flags !== 4'b0111) begin errors++; $display("FAIL carry_flags: got %b want 0111", o_flags); end
  endtask

  task automatic test_logic_shift();
    issue(1, 5'b00000, 2'd0, 0, 1, 11'd0, 16'h00F0);
    issue(1, 5'b01001, 2'd2, 1, 1, 11'h03C, 16'h0);
    checks++; if (o_data !== 16'h0030) begin errors++; $display("FAIL andi_acc: got %h want 0030", o_data); end
    checks++; if (o_flags !== 4'b0000) begin errors++; $display("FAIL andi_flags: got %b want 0000", o_flags); end
    issue(1, 5'b01110, 2'd2, 1, 1, 11'd4, 16'h0);
    checks++; if (o_data !== 16'h0300) begin errors++; $display("FAIL shl_acc: got %h want 0300", o_data); end
    issue(1, 5'b00000, 2'd0, 0, 1, 11'd0, 16'h8001);
    issue(1, 5'b01111, 2'd2, 1, 1, 11'd1, 16'h0);
    checks++; if (o_data !== 16'hC000) begin errors++; $display("FAIL sar_acc: got %h want c000", o_data); end
    checks++; if (o_flags !== 4'b1010) begin errors++; $display("FAIL sar_flags: got %b want 1010", o_flags); end
  endtask

  task automatic test_no_accept();
    issue(0, 5'b00101, 2'd2, 1, 1, 11'd9, 16'h0);
    checks++; if (o_data !== 16'hC000) begin errors++; $display("FAIL noaccept_acc: got %h want c000", o_data); end
    issue(1, 5'b00101, 2'd2, 1, 0, 11'd9, 16'h0);
    checks++; if (o_data !== 16'hC000 || o_flags !== 4'b1010) begin errors++; $display("FAIL nowrite: got %h/%b want c000/1010", o_data, o_flags); end
    issue(1, 5'b00000, 2'd3, 0, 1, 11'd0, 16'h1111);
    checks++; if (o_data !== 16'hC000) begin errors++; $display("FAIL hold_acc: got %h want c000", o_data); end
    issue(1, 5'b00000, 2'd1, 0, 1, 11'h7FF, 16'h0);
    checks++; if (o_data !== 16'hFFFF || o_flags !== 4'b1010) begin errors++; $display("FAIL sext_load: got %h/%b want ffff/1010", o_data, o_flags); end
  endtask

  task automatic test_random();
    logic [4:0] ops [19];
    ops = '{5'b00000, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
            5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000,
            5'b00001, 5'b00011, 5'b10001, 5'b11111, 5'b01110};
    for (int k = 0; k < 300; k++) begin
      logic [4:0] op;
      op = ops[$urandom_range(0, 18)];
      if (MUL_ON && op == 5'b10000) op = 5'b00101;
      issue($urandom_range(0, 3) != 0, op, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
            11'($urandom), 16'($urandom));
      checks++; if (o_data !== m_acc) begin errors++; $display("FAIL rand_acc[%0d]: op %b got %h want %h", k, op, o_data, m_acc); end
      checks++; if (o_flags !== m_flags) begin errors++; $display("FAIL rand_flags[%0d]: op %b got %b want %b", k, op, o_flags, m_flags); end
    end
  endtask

`ifdef BIP_MUL_EN
  task automatic test_mul();
    int cyc;
    issue(1, 5'b00000, 2'd0, 0, 1, 11'd0, 16'd300);
    issue(1, 5'b10000, 2'd2, 0, 1, 11'd0, 16'd200);
    cyc = 0;
    while (o_busy === 1'b1 && cyc < 40) begin
      cyc++;
      checks++; if (o_ready !== 1'b0 || o_data !== 16'd300) begin errors++; $display("FAIL mul_busy_state: ready %b acc %h want 0/012c", o_ready, o_data); end
      @(negedge i_clk);
      if (cyc == 3) begin
        i_valid = 1'b1; i_op = 5'b00101; i_selA = 2'd2; i_selB = 1'b1;
        i_wrAcc = 1'b1; i_operando = 11'd1;
      end else i_valid = 1'b0;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    checks++; if (cyc !== 16) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 16", cyc); end
    checks++; if (o_data !== 16'hEA60) begin errors++; $display("FAIL mul_acc: got %h want ea60", o_data); end
    checks++; if (o_flags !== 4'b1000) begin errors++; $display("FAIL mul_flags: got %b want 1000", o_flags); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mul_ready: got %b want 1", o_ready); end
    m_acc = 16'hEA60; m_flags = 4'b1000;
    issue(1, 5'b00000, 2'd0, 0, 1, 11'd0, 16'h0100);
    issue(1, 5'b10000, 2'd2, 1, 1, 11'h100, 16'h0);
    cyc = 0;
    while (o_busy === 1'b1 && cyc < 40) begin cyc++; @(posedge i_clk); #1; end
    checks++; if (o_data !== 16'h0000 || o_flags !== 4'b0110) begin errors++; $display("FAIL mul_wrap: got %h/%b want 0000/0110", o_data, o_flags); end
    issue(1, 5'b00000, 2'd0, 0, 1, 11'd0, 16'h0007);
    issue(1, 5'b10000, 2'd2, 1, 0, 11'd9, 16'h0);
    cyc = 0;
    while (o_busy === 1'b1 && cyc < 40) begin cyc++; @(posedge i_clk); #1; end
    checks++; if (o_data !== 16'h0007 || o_flags !== 4'b0110 || cyc !== 16) begin errors++; $display("FAIL mul_nowrite: got %h/%b cyc %0d want 0007/0110 cyc 16", o_data, o_flags, cyc); end
    m_acc = 16'h0007; m_flags = 4'b0110;
  endtask

  task automatic test_mul_reset();
    issue(1, 5'b00000, 2'd0, 0, 1, 11'd0, 16'd300);
    issue(1, 5'b10000, 2'd2, 0, 1, 11'd0, 16'd200);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk); #2;
    i_rst = 1'b0;
    #1;
    checks++; if (o_data !== 16'h0000 || o_flags !== 4'b0000 || o_busy !== 1'b0) begin errors++; $display("FAIL mul_reset: got %h/%b busy %b want 0000/0000 busy 0", o_data, o_flags, o_busy); end
    @(negedge i_clk); i_rst = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mul_reset_ready: got %b want 1", o_ready); end
    repeat (20) @(posedge i_clk);
    #1;
    checks++; if (o_data !== 16'h0000 || o_busy !== 1'b0) begin errors++; $display("FAIL mul_reset_abort: got %h busy %b want 0000 busy 0", o_data, o_busy); end
    m_acc = '0; m_flags = '0;
  endtask
`else
  task automatic test_mul_disabled();
    issue(1, 5'b00000, 2'd0, 0, 1, 11'd0, 16'h8000);
    issue(1, 5'b00100, 2'd2, 0, 1, 11'd0, 16'h8000);
    issue(1, 5'b00000, 2'd0, 0, 1, 11'd0, 16'h1234);
    issue(1, 5'b10000, 2'd2, 1, 1, 11'd3, 16'h0);
    checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL nomul_handshake: busy %b ready %b want 0/1", o_busy, o_ready); end
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (o_data !== 16'h1234 || o_flags !== 4'b0111 || o_busy !== 1'b0) begin errors++; $display("FAIL nomul_hold: got %h/%b busy %b want 1234/0111 busy 0", o_data, o_flags, o_busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_logic_shift();
    test_no_accept();
`ifdef BIP_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
